// File: rtl/pc_fetch_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_pkg
//  Shared definitions for the PC fetch unit: default datapath width, the reset
//  PC and the fetch FSM state encoding.
//  Contents:
//    WIDTH     default address/data width
//    RESET_PC  default PC after reset (the external incrementer resets to 1)
//    state_t   FSM state type; S_IDLE, S_REQ, S_HOLD constants
// -----------------------------------------------------------------------------
package pc_fetch_pkg;

  localparam int          WIDTH    = 32;
  localparam int unsigned RESET_PC = 0;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;  // no request outstanding
  localparam state_t S_REQ  = 2'd1;  // imem_req high, waiting for imem_ack
  localparam state_t S_HOLD = 2'd2;  // word captured, waiting for downstream

endpackage

// File: rtl/pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
//  Architectural PC register. On load it takes either the branch target or the
//  incrementer result; it never adds anything itself, so any wrap-around in
//  pc_soma is passed straight through.
//  Ports:
//    clock          in   rising-edge clock
//    reset          in   asynchronous active-high reset (pc <= RESET_PC)
//    load           in   update the PC this cycle (instruction consumed)
//    branch_taken   in   choose branch_target instead of pc_soma
//    branch_target  in   WIDTH  branch destination
//    pc_soma        in   WIDTH  registered pc+1 from the external incrementer
//    pc             out  WIDTH  current PC
// -----------------------------------------------------------------------------
import pc_fetch_pkg::*;

module pc_next_sel #(
  parameter int               WIDTH    = pc_fetch_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(pc_fetch_pkg::RESET_PC)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] pc_soma,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;

  always_comb begin
    pc_next = branch_taken ? branch_target : pc_soma;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_reg <= RESET_PC;
    end else if (load) begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//  Holds the architectural PC, drives the instruction-memory request/ack
//  handshake and presents fetched words downstream with valid/ready. Each
//  consumed word loads the next PC from pc_soma or from a branch target.
//  Optional feature macro: PC_FETCH_CNT_EN -- when defined, fetch_count counts
//  consumed instructions (wrapping); otherwise fetch_count is tied to 0.
//  Ports:
//    clock, reset    rising-edge clock, asynchronous active-high reset
//    pc_soma         in   registered pc+1 from the incrementer
//    branch_taken    in   at consume: next PC = branch_target
//    branch_target   in   branch destination
//    stall           in   hold off new fetch requests
//    pc              out  current PC (to incrementer)
//    imem_req        out  fetch request
//    imem_addr       out  fetch address (equals pc)
//    imem_ack        in   memory returns imem_data this cycle
//    imem_data       in   fetched word
//    instr           out  captured instruction
//    instr_valid     out  instr holds an unconsumed word
//    instr_ready     in   downstream accepts instr
//    fetch_count     out  consumed-instruction count
// -----------------------------------------------------------------------------
import pc_fetch_pkg::*;

module pc_fetch_unit #(
  parameter int               WIDTH    = pc_fetch_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(pc_fetch_pkg::RESET_PC)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_soma,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             stall,
  output logic [WIDTH-1:0] pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_data,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] fetch_count
);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] instr_reg;
  logic [WIDTH-1:0] instr_next;
  logic             instr_valid_reg;
  logic             instr_valid_next;
  logic             consume;

  assign consume = (state_reg == S_HOLD) && instr_valid_reg && instr_ready;

  // Stall is only looked at when deciding whether to start a new request; once
  // S_REQ is entered the request is held until the memory acknowledges it.
  always_comb begin
    state_next       = state_reg;
    instr_next       = instr_reg;
    instr_valid_next = instr_valid_reg;
    case (state_reg)
      S_IDLE: begin
        if (!stall) begin
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_ack) begin
          instr_next       = imem_data;
          instr_valid_next = 1'b1;
          state_next       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (consume) begin
          instr_valid_next = 1'b0;
          state_next       = stall ? S_IDLE : S_REQ;
        end
      end
      default: begin
        // Unused encoding: fall back to idle with nothing pending.
        instr_valid_next = 1'b0;
        state_next       = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      instr_reg       <= '0;
      instr_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      instr_reg       <= instr_next;
      instr_valid_reg <= instr_valid_next;
    end
  end

  pc_next_sel #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_next_sel (
    .clock         (clock),
    .reset         (reset),
    .load          (consume),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_soma       (pc_soma),
    .pc            (pc)
  );

  assign imem_req    = (state_reg == S_REQ);
  assign imem_addr   = pc;
  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;

`ifdef PC_FETCH_CNT_EN
  logic [WIDTH-1:0] fetch_count_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count_reg <= '0;
    end else if (consume) begin
      fetch_count_reg <= fetch_count_reg + WIDTH'(1);
    end
  end

  assign fetch_count = fetch_count_reg;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
`timescale 1ns/1ps

module tb_pc_fetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] pc_soma;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit dut (
    .clock         (clock),
    .reset         (reset),
    .pc_soma       (pc_soma),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .pc            (pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .fetch_count   (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External incrementer: registered pc+1, resets to 1.
  always @(posedge clock or posedge reset) begin
    if (reset) pc_soma <= 32'd1;
    else       pc_soma <= pc + 32'd1;
  end

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_data = word(imem_addr);

  function automatic logic [31:0] cnt_exp(input int c);
    logic [31:0] r;
`ifdef PC_FETCH_CNT_EN
    r = 32'(c);
`else
    r = 32'd0;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        ack;
    logic        ready;
    logic        bt;
    logic [31:0] tgt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_iaddr;
    int          exp_cnt;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic a, input logic r, input logic b,
                              input logic [31:0] t, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep, input logic [31:0] ei,
                              input int ec);
    vec_t v;
    v.stall = s; v.ack = a; v.ready = r; v.bt = b; v.tgt = t;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
    v.exp_iaddr = ei; v.exp_cnt = ec;
    return v;
  endfunction

  vec_t tbl[31];

  // Reference model state for the random phase
  logic        m_req;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  int          m_cnt;

  task automatic pulse_reset();
    @(negedge clock);
    stall = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b1;
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;

    // Each record: inputs for the coming edge, expected outputs seen just before it.
    //            st ack rdy bt tgt       req addr   vld pc     iaddr  cnt
    tbl[0]  = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  32'h0,  0);
    tbl[1]  = mk(0, 0, 0, 0, 32'h0,  1, 32'h0,  0, 32'h0,  32'h0,  0);
    tbl[2]  = mk(0, 1, 0, 0, 32'h0,  1, 32'h0,  0, 32'h0,  32'h0,  0);
    tbl[3]  = mk(0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 32'h0,  32'h0,  0);
    tbl[4]  = mk(0, 0, 0, 0, 32'h0,  1, 32'h1,  0, 32'h1,  32'h0,  1);
    tbl[5]  = mk(0, 1, 0, 0, 32'h0,  1, 32'h1,  0, 32'h1,  32'h0,  1);
    tbl[6]  = mk(0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 32'h1,  32'h1,  1);
    tbl[7]  = mk(0, 0, 0, 0, 32'h0,  1, 32'h2,  0, 32'h2,  32'h0,  2);
    tbl[8]  = mk(0, 1, 0, 0, 32'h0,  1, 32'h2,  0, 32'h2,  32'h0,  2);
    tbl[9]  = mk(0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 32'h2,  32'h2,  2);
    tbl[10] = mk(0, 0, 0, 0, 32'h0,  1, 32'h3,  0, 32'h3,  32'h0,  3);
    tbl[11] = mk(0, 1, 0, 0, 32'h0,  1, 32'h3,  0, 32'h3,  32'h0,  3);
    tbl[12] = mk(0, 0, 1, 1, 32'h40, 0, 32'h0,  1, 32'h3,  32'h3,  3);
    tbl[13] = mk(0, 1, 0, 0, 32'h0,  1, 32'h40, 0, 32'h40, 32'h0,  4);
    tbl[14] = mk(0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 32'h40, 32'h40, 4);
    tbl[15] = mk(1, 1, 0, 0, 32'h0,  1, 32'h41, 0, 32'h41, 32'h0,  5);
    tbl[16] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,  1, 32'h41, 32'h41, 5);
    tbl[17] = mk(1, 0, 0, 1, 32'h99, 0, 32'h0,  1, 32'h41, 32'h41, 5);
    tbl[18] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,  1, 32'h41, 32'h41, 5);
    tbl[19] = mk(1, 0, 0, 0, 32'h0,  0, 32'h0,  1, 32'h41, 32'h41, 5);
    tbl[20] = mk(1, 0, 1, 0, 32'h0,  0, 32'h0,  1, 32'h41, 32'h41, 5);
    tbl[21] = mk(1, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h42, 32'h0,  6);
    tbl[22] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h42, 32'h0,  6);
    tbl[23] = mk(1, 0, 0, 0, 32'h0,  1, 32'h42, 0, 32'h42, 32'h0,  6);
    tbl[24] = mk(0, 0, 0, 0, 32'h0,  1, 32'h42, 0, 32'h42, 32'h0,  6);
    tbl[25] = mk(1, 0, 0, 0, 32'h0,  1, 32'h42, 0, 32'h42, 32'h0,  6);
    tbl[26] = mk(0, 0, 0, 0, 32'h0,  1, 32'h42, 0, 32'h42, 32'h0,  6);
    tbl[27] = mk(1, 0, 0, 0, 32'h0,  1, 32'h42, 0, 32'h42, 32'h0,  6);
    tbl[28] = mk(0, 1, 0, 0, 32'h0,  1, 32'h42, 0, 32'h42, 32'h0,  6);
    tbl[29] = mk(1, 0, 1, 0, 32'h0,  0, 32'h0,  1, 32'h42, 32'h42, 6);
    tbl[30] = mk(1, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h43, 32'h0,  7);

    // Reset state (sampled while reset is held)
    @(negedge clock);
    @(negedge clock);
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_cnt", fetch_count, 32'h0);
    reset = 1'b0;

    // Directed sequence: in-order fetch, branch, ack wait, ready hold, stall at consume
    for (int k = 0; k < 31; k++) begin
      @(negedge clock);
      chk($sformatf("v%0d_req", k), {31'd0, imem_req}, {31'd0, tbl[k].exp_req});
      chk($sformatf("v%0d_pc", k), pc, tbl[k].exp_pc);
      chk($sformatf("v%0d_valid", k), {31'd0, instr_valid}, {31'd0, tbl[k].exp_valid});
      chk($sformatf("v%0d_cnt", k), fetch_count, cnt_exp(tbl[k].exp_cnt));
      if (tbl[k].exp_req)   chk($sformatf("v%0d_addr", k), imem_addr, tbl[k].exp_addr);
      if (tbl[k].exp_valid) chk($sformatf("v%0d_instr", k), instr, word(tbl[k].exp_iaddr));
      $display("vec %0d: pc=%h req=%0d addr=%h valid=%0d instr=%h", k, pc, imem_req,
               imem_addr, instr_valid, instr);
      stall = tbl[k].stall; imem_ack = tbl[k].ack; instr_ready = tbl[k].ready;
      branch_taken = tbl[k].bt; branch_target = tbl[k].tgt;
    end

    // Reset during S_REQ, then a stray ack must be ignored
    @(negedge clock);
    stall = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0;
    @(negedge clock);
    chk("r6_req_before", {31'd0, imem_req}, 32'd1);
    chk("r6_addr_before", imem_addr, 32'h43);
    #2 reset = 1'b1;
    #1;
    chk("r6_async_pc", pc, 32'h0);
    chk("r6_async_req", {31'd0, imem_req}, 32'd0);
    chk("r6_async_valid", {31'd0, instr_valid}, 32'd0);
    chk("r6_async_cnt", fetch_count, 32'h0);
    @(negedge clock);
    reset = 1'b0; stall = 1'b1; imem_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      chk("r6_stray_valid", {31'd0, instr_valid}, 32'd0);
      chk("r6_stray_instr", instr, 32'h0);
      chk("r6_stray_pc", pc, 32'h0);
      chk("r6_stray_req", {31'd0, imem_req}, 32'd0);
    end
    imem_ack = 1'b0; stall = 1'b0;
    @(negedge clock);
    chk("r6_req_after", {31'd0, imem_req}, 32'd1);
    chk("r6_addr_after", imem_addr, 32'h0);
    $display("reset-during-request sequence done: pc=%h valid=%0d", pc, instr_valid);

    // Random phase against the reference model
    pulse_reset();
    m_req = 1'b0; m_valid = 1'b0; m_pc = 32'h0; m_instr = 32'h0; m_cnt = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic s, a, r, b;
      logic [31:0] t;
      @(negedge clock);
      chk("rnd_req", {31'd0, imem_req}, {31'd0, m_req});
      chk("rnd_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      chk("rnd_pc", pc, m_pc);
      chk("rnd_cnt", fetch_count, cnt_exp(m_cnt));
      if (m_req)   chk("rnd_addr", imem_addr, m_pc);
      if (m_valid) chk("rnd_instr", instr, m_instr);

      s = ($urandom_range(3) == 0);
      a = m_req ? ($urandom_range(2) != 0) : ($urandom_range(7) == 0);
      r = ($urandom_range(2) != 0);
      b = ($urandom_range(3) == 0);
      t = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
      stall = s; imem_ack = a; instr_ready = r; branch_taken = b; branch_target = t;

      // What the next clock edge does, from the handshake rules
      if (m_valid) begin
        if (r) begin
          m_pc = b ? t : pc_soma;
          m_cnt++;
          m_valid = 1'b0;
          m_req = !s;
          $display("consume %0d: instr=%h next_pc=%h branch=%0d", m_cnt, m_instr, m_pc, b);
        end
      end else if (m_req) begin
        if (a) begin
          m_instr = word(m_pc);
          m_valid = 1'b1;
          m_req = 1'b0;
        end
      end else if (!s) begin
        m_req = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
